// File: rtl/food_placer.sv
// ============================================================================
// Module   : food_placer
// Purpose  : Picks a random free cell for the next food item, asking the
//            snake-body lookup whether each candidate is occupied.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module food_placer #(
    parameter int unsigned X_MAX     = 627,
    parameter int unsigned Y_MAX     = 452,
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned FOOD_X0   = 302,
    parameter int unsigned FOOD_Y0   = 227
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       place_req,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    output logic       occ_valid,
    output logic [9:0] occ_x,
    output logic [9:0] occ_y,
    input  logic       occ_ready,
    input  logic       occ_hit,
    output logic [9:0] food_x,
    output logic [9:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam logic [9:0] c_X_MAX     = 10'(X_MAX);
    localparam logic [9:0] c_Y_MAX     = 10'(Y_MAX);
    localparam logic [3:0] c_MAX_TRIES = 4'(MAX_TRIES);
    localparam logic [9:0] c_FOOD_X0   = 10'(FOOD_X0);
    localparam logic [9:0] c_FOOD_Y0   = 10'(FOOD_Y0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_CHECK  = 3'd2,
        S_QUERY  = 3'd3,
        S_COMMIT = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t     r_state;
    logic [3:0] r_tries;
    logic [9:0] r_cand_x;
    logic [9:0] r_cand_y;
    logic [9:0] r_food_x;
    logic [9:0] r_food_y;
    logic       r_food_valid;
    logic       r_occ_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_fail;

    logic [3:0] w_tries_inc;
    logic       w_out_of_range;

    // MAX_TRIES is at most 15, so the incremented count never wraps.
    assign w_tries_inc    = r_tries + 4'd1;
    assign w_out_of_range = (r_cand_x > c_X_MAX) || (r_cand_y > c_Y_MAX);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_tries      <= 4'd0;
            r_cand_x     <= 10'd0;
            r_cand_y     <= 10'd0;
            r_food_x     <= c_FOOD_X0;
            r_food_y     <= c_FOOD_Y0;
            r_food_valid <= 1'b1;
            r_occ_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (place_req) begin
                        r_state      <= S_SAMPLE;
                        r_busy       <= 1'b1;
                        r_food_valid <= 1'b0;
                        r_tries      <= 4'd0;
                    end
                end
                S_SAMPLE: begin
                    r_cand_x <= rand_x;
                    r_cand_y <= rand_y;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_out_of_range) begin
                        r_tries <= w_tries_inc;
                        if (w_tries_inc == c_MAX_TRIES) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end else begin
                        r_state     <= S_QUERY;
                        r_occ_valid <= 1'b1;
                    end
                end
                S_QUERY: begin
                    if (occ_ready) begin
                        r_occ_valid <= 1'b0;
                        if (occ_hit) begin
                            r_tries <= w_tries_inc;
                            if (w_tries_inc == c_MAX_TRIES) begin
                                r_state <= S_FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state <= S_SAMPLE;
                            end
                        end else begin
                            // Food moves on the same edge done rises so both are seen together.
                            r_state      <= S_COMMIT;
                            r_food_x     <= r_cand_x;
                            r_food_y     <= r_cand_y;
                            r_food_valid <= 1'b1;
                            r_done       <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_FAIL: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_occ_valid <= 1'b0;
                end
            endcase
        end
    end

    assign occ_valid  = r_occ_valid;
    assign occ_x      = r_cand_x;
    assign occ_y      = r_cand_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;

endmodule

`default_nettype wire

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Parameter X_MAX, default 627, largest legal food X coordinate (inclusive).
REQ-002 Parameter Y_MAX, default 452, largest legal food Y coordinate (inclusive).
REQ-003 Parameter MAX_TRIES, default 8, candidate attempts per placement before giving up (range 1..15).
REQ-004 Parameter FOOD_X0 / FOOD_Y0, defaults 302 / 227, food position loaded at reset.
REQ-005 clock  in  1  single system clock, all logic on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 place_req  in  1  request new food position (food eaten / game start).
REQ-008 rand_x, rand_y  in  10 each  candidate coordinates from random generator, new value every cycle.
REQ-009 occ_valid  out  1  occupancy query valid to snake-body lookup.
REQ-010 occ_x, occ_y  out  10 each  coordinate being queried, stable while occ_valid=1.
REQ-011 occ_ready  in  1  lookup accepts query and presents result this cycle.
REQ-012 occ_hit  in  1  queried cell occupied by snake; meaningful only when occ_valid & occ_ready.
REQ-013 food_x, food_y  out  10 each  current food position.
REQ-014 food_valid  out  1  food position is placed and displayable.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a new position is committed.
REQ-017 fail  out  1  one-cycle pulse when MAX_TRIES attempts exhausted.

Function
REQ-018 FSM states: IDLE, SAMPLE, CHECK, QUERY, COMMIT, FAIL; encoding free.
REQ-019 IDLE: place_req=1 -> SAMPLE next cycle; food_valid cleared same edge; try counter cleared to 0.
REQ-020 place_req while busy=1 SHALL be ignored (not queued).
REQ-021 SAMPLE: register rand_x/rand_y into candidate registers; -> CHECK.
REQ-022 CHECK: candidate_x>X_MAX or candidate_y>Y_MAX counts as a failed try; otherwise -> QUERY.
REQ-023 QUERY: occ_valid=1, occ_x/occ_y = candidate; state held until occ_ready=1, no timeout.
REQ-024 QUERY with occ_ready=1: occ_hit=1 counts as failed try; occ_hit=0 -> COMMIT.
REQ-025 Failed try: counter increments; if new count == MAX_TRIES -> FAIL, else -> SAMPLE (fresh rand sampled one cycle later).
REQ-026 COMMIT: food_x/food_y <= candidate, food_valid <= 1, done=1 for exactly this cycle; -> IDLE.
REQ-027 FAIL: fail=1 for exactly this cycle; food_x/food_y unchanged; food_valid stays 0; -> IDLE.
REQ-028 Try counter 4 bits, never wraps; comparisons unsigned; coordinates 10-bit unsigned, no arithmetic on them.
REQ-029 occ_valid SHALL be 0 in every state except QUERY.
REQ-030 done and fail SHALL never be high in the same cycle.
REQ-031 Latency, first candidate accepted with occ_ready tied high: place_req edge -> done pulse 4 cycles later (SAMPLE, CHECK, QUERY, COMMIT).

Reset
REQ-032 reset_n=0 at a rising edge: state=IDLE, food_x=FOOD_X0, food_y=FOOD_Y0, food_valid=1, try counter=0, candidates=0.
REQ-033 During/after reset cycle: occ_valid=0, busy=0, done=0, fail=0, occ_x=occ_y=0.
REQ-034 Reset asserted mid-placement (any state) SHALL abort it with no done/fail pulse; reset wins over place_req and occ_ready in same cycle.

Verification
REQ-035 Reset, then idle -> food_x=302, food_y=227, food_valid=1, busy=0.
REQ-036 occ_ready=1, occ_hit=0, rand=(52,77), place_req pulse -> occ query (52,77), done 4 cycles later, food=(52,77), food_valid=1.
REQ-037 rand_x=700 for first sample then (127,102), occ_hit=0 -> first try rejected in CHECK, no occ_valid for it, commit (127,102), done on cycle 6.
REQ-038 occ_hit=1 always, MAX_TRIES=8 -> exactly 8 queries, fail pulse once, no done, food_valid=0, food position unchanged.
REQ-039 occ_ready held low 10 cycles in QUERY -> occ_valid and occ_x/occ_y stable throughout; second place_req ignored; commit after ready.
REQ-040 reset_n=0 while in QUERY -> next cycle IDLE, occ_valid=0, food=(302,227), food_valid=1, no done/fail pulse.
